data_mem_ctrl: RTL

Word-addressed data memory controller. It sits directly downstream of the load/store unit and answers that unit's data requests. It advertises readiness on a grant line, captures one request per transaction, and inserts a programmable number of wait states. It then returns load data, or a store acknowledgement, together with an error flag for misaligned or out-of-window addresses.

---
 rtl/data_mem_ctrl_pkg.sv | 14 +
 rtl/data_mem_ctrl_dmem_array.sv | 24 ++
 rtl/data_mem_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and default geometry for the data memory controller.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_BASE_ADDR   = 512;
    localparam int DMEM_DEPTH_WORDS = 2049;
    localparam int DMEM_LAST_ADDR   = DMEM_BASE_ADDR + 4 * (DMEM_DEPTH_WORDS - 1);

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// Word storage behind the controller: synchronous write, combinational read.
module dmem_array #(
    parameter int DEPTH_WORDS = 2049,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_index,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Contents survive reset; only the controller decides when a write lands.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: grants one load/store at a time, waits a fixed
// number of cycles, then strobes the response with an address error flag.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LO_ADDR   = 33'(BASE_ADDR);
    localparam logic [32:0] HI_ADDR   = 33'(BASE_ADDR) + 33'(4 * (DEPTH_WORDS - 1));
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t r_state;
    dmem_state_t w_nextState;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;

    logic             w_accept;
    logic             w_addrOk;
    logic [IDX_W-1:0] w_index;
    logic [31:0]      w_arrayRdata;
    logic             w_memWe;
    logic             w_inResp;

    assign w_accept = (r_state == IDLE) && data_req_i;
    assign w_inResp = (r_state == RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_addr  <= data_addr_i;
                r_we    <= data_we_i;
                r_wdata <= data_wdata_i;
                r_cnt   <= WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (data_req_i) begin
                    w_nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_nextState = RESP;
                end
            end
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Index is forced to 0 on a bad address so the array is never read out of range.
    assign w_addrOk = (r_addr[1:0] == 2'b00) &&
                      ({1'b0, r_addr} >= LO_ADDR) &&
                      ({1'b0, r_addr} <= HI_ADDR);
    assign w_index  = w_addrOk ? IDX_W'((r_addr - 32'(BASE_ADDR)) >> 2) : '0;

    // Store commits on the edge closing RESP, unless reset abandons it.
    assign w_memWe = w_inResp && r_we && w_addrOk && !reset;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clock  (clock),
        .i_we   (w_memWe),
        .i_index(w_index),
        .i_wdata(r_wdata),
        .o_rdata(w_arrayRdata)
    );

    assign data_gnt_o    = (r_state == IDLE) && !reset;
    assign data_rvalid_o = w_inResp;
    assign data_err_o    = w_inResp && !w_addrOk;
    assign data_rdata_o  = (w_inResp && w_addrOk && !r_we) ? w_arrayRdata : 32'd0;

endmodule
